// File: rtl/instr_adr_ctrl.sv
// Instruction address sequencer: holds the fetch pstate pair, advances it,
// arbitrates redirects (TRAP > EX > OF > FD) and drives the stage flushes.
module instr_adr_ctrl #(
  parameter int unsigned WORD_LENGTH = 32,
  parameter logic [WORD_LENGTH-1:0] RESET_PSTATE0 = '0,
  parameter logic [WORD_LENGTH-1:0] RESET_PSTATE1 = '0,
  parameter int unsigned INSTR_INC = 4,
  parameter int unsigned TRAP_BUBBLE = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inFdReady,
  input  logic                   inFdRedirect,
  input  logic                   inOfRedirect,
  input  logic                   inExRedirect,
  input  logic                   inTrapReq,
  input  logic [WORD_LENGTH-1:0] inFdPstate0,
  input  logic [WORD_LENGTH-1:0] inFdPstate1,
  input  logic [WORD_LENGTH-1:0] inOfPstate0,
  input  logic [WORD_LENGTH-1:0] inOfPstate1,
  input  logic [WORD_LENGTH-1:0] inExPstate0,
  input  logic [WORD_LENGTH-1:0] inExPstate1,
  input  logic [WORD_LENGTH-1:0] inTrapPstate0,
  input  logic [WORD_LENGTH-1:0] inTrapPstate1,
  input  logic                   inHaltReq,
  input  logic                   inResume,
  output logic [WORD_LENGTH-1:0] outPstate0,
  output logic [WORD_LENGTH-1:0] outPstate1,
  output logic                   outValid,
  output logic                   outFlushFd,
  output logic                   outFlushOf,
  output logic                   outFlushEx,
  output logic [1:0]             outState
);

  localparam int unsigned CW = $clog2(TRAP_BUBBLE + 1);
  localparam logic [CW-1:0] BUBBLE = CW'(TRAP_BUBBLE);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [WORD_LENGTH-1:0] INC = WORD_LENGTH'(INSTR_INC);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2,
    HALT = 2'd3
  } state_e;

  state_e state_q, state_d;
  logic [WORD_LENGTH-1:0] cur0_q, cur0_d;
  logic [WORD_LENGTH-1:0] cur1_q, cur1_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic sel_trap, sel_ex, sel_of, sel_fd;
  logic sel_redir;
  logic [WORD_LENGTH-1:0] tgt0, tgt1;

  // Fixed-priority winner; losers are simply dropped.
  always_comb begin
    sel_trap = inTrapReq;
    sel_ex   = !inTrapReq && inExRedirect;
    sel_of   = !inTrapReq && !inExRedirect && inOfRedirect;
    sel_fd   = !inTrapReq && !inExRedirect && !inOfRedirect
               && inFdRedirect;
    sel_redir = sel_ex || sel_of || sel_fd;
  end

  always_comb begin
    tgt0 = inFdPstate0;
    tgt1 = inFdPstate1;
    unique case (1'b1)
      sel_ex: begin
        tgt0 = inExPstate0;
        tgt1 = inExPstate1;
      end
      sel_of: begin
        tgt0 = inOfPstate0;
        tgt1 = inOfPstate1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      cur0_q  <= RESET_PSTATE0;
      cur1_q  <= RESET_PSTATE1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cur0_q  <= cur0_d;
      cur1_q  <= cur1_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (sel_trap) begin
          state_d = TRAP;
          cnt_d   = BUBBLE;
        end else if (!sel_redir && inHaltReq) begin
          state_d = HALT;
        end
      end
      TRAP: begin
        if (sel_trap) begin
          cnt_d = BUBBLE;
        end else if (cnt_q <= ONE) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      HALT: begin
        if (sel_trap) begin
          state_d = TRAP;
          cnt_d   = BUBBLE;
        end else if (inResume) begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // Address datapath: trap loads anywhere past BOOT, others only in RUN.
  always_comb begin
    cur0_d = cur0_q;
    cur1_d = cur1_q;
    if (state_q != BOOT && sel_trap) begin
      cur0_d = inTrapPstate0;
      cur1_d = inTrapPstate1;
    end else if (state_q == RUN) begin
      if (sel_redir) begin
        cur0_d = tgt0;
        cur1_d = tgt1;
      end else if (!inHaltReq && inFdReady) begin
        cur1_d = cur1_q + INC;
      end
    end
  end

  always_comb begin
    outValid   = (state_q == RUN);
    outFlushFd = 1'b0;
    outFlushOf = 1'b0;
    outFlushEx = 1'b0;
    if (state_q != BOOT && sel_trap) begin
      outFlushFd = 1'b1;
      outFlushOf = 1'b1;
      outFlushEx = 1'b1;
    end else if (state_q == RUN) begin
      outFlushFd = sel_ex || sel_of;
      outFlushOf = sel_ex;
    end
  end

  assign outPstate0 = cur0_q;
  assign outPstate1 = cur1_q;
  assign outState   = state_q;

endmodule
